// File: rtl/grayscale_pkg.sv
// Shared definitions for the RGB565 capture-to-luma path: default luma weights and byte phase.
package grayscale_pkg;

  localparam int unsigned LUMA_COEFF_R = 77;
  localparam int unsigned LUMA_COEFF_G = 150;
  localparam int unsigned LUMA_COEFF_B = 29;
  localparam int unsigned LUMA_SHIFT   = 8;

  typedef enum logic {EXPECT_FIRST, EXPECT_SECOND} byte_phase_t;

  // Replicate the top bits into the low bits so full-scale maps to 255.
  function automatic logic [7:0] expand5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  function automatic logic [7:0] expand6(input logic [5:0] c);
    return {c, c[5:4]};
  endfunction

endpackage

// File: rtl/rgb565_luma_pipe.sv
// RGB565 word -> 8-bit luma: expand, multiply, sum/shift; fixed two-cycle latency after launch.
// Rounding (+128 before the shift) is enabled by defining RGB565_TO_GRAYSCALE_ROUND_EN.
module rgb565_luma_pipe
  import grayscale_pkg::*;
#(
  parameter int unsigned coeff_r = LUMA_COEFF_R,
  parameter int unsigned coeff_g = LUMA_COEFF_G,
  parameter int unsigned coeff_b = LUMA_COEFF_B
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        word_valid,
  input  logic [15:0] word,
  output logic        luma_valid,
  output logic [7:0]  luma
);

  localparam logic [7:0] CoeffR = 8'(coeff_r);
  localparam logic [7:0] CoeffG = 8'(coeff_g);
  localparam logic [7:0] CoeffB = 8'(coeff_b);

`ifdef RGB565_TO_GRAYSCALE_ROUND_EN
  localparam logic [16:0] RoundBias = 17'd128;
`else
  localparam logic [16:0] RoundBias = 17'd0;
`endif

  logic [7:0]  r8_q, g8_q, b8_q;
  logic        s0_valid_q;
  logic [15:0] prod_r_q, prod_g_q, prod_b_q;
  logic        s1_valid_q;
  logic [15:0] prod_r_d, prod_g_d, prod_b_d;
  logic [16:0] sum;
  logic [7:0]  luma_d;
  logic        luma_valid_q;
  logic [7:0]  luma_q;

  always_comb begin
    prod_r_d = 16'(CoeffR) * 16'(r8_q);
    prod_g_d = 16'(CoeffG) * 16'(g8_q);
    prod_b_d = 16'(CoeffB) * 16'(b8_q);
    // Weights sum to 256, so the shifted result always fits in 8 bits.
    sum      = {1'b0, prod_r_q} + {1'b0, prod_g_q} + {1'b0, prod_b_q} + RoundBias;
    luma_d   = 8'(sum >> LUMA_SHIFT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r8_q         <= '0;
      g8_q         <= '0;
      b8_q         <= '0;
      s0_valid_q   <= 1'b0;
      prod_r_q     <= '0;
      prod_g_q     <= '0;
      prod_b_q     <= '0;
      s1_valid_q   <= 1'b0;
      luma_valid_q <= 1'b0;
      luma_q       <= '0;
    end else begin
      s0_valid_q   <= word_valid;
      s1_valid_q   <= s0_valid_q;
      luma_valid_q <= s1_valid_q;
      if (word_valid) begin
        r8_q <= expand5(word[15:11]);
        g8_q <= expand6(word[10:5]);
        b8_q <= expand5(word[4:0]);
      end
      if (s0_valid_q) begin
        prod_r_q <= prod_r_d;
        prod_g_q <= prod_g_d;
        prod_b_q <= prod_b_d;
      end
      if (s1_valid_q) begin
        luma_q <= luma_d;
      end
    end
  end

  assign luma_valid = luma_valid_q;
  assign luma       = luma_q;

endmodule

// File: rtl/rgb565_to_grayscale.sv
// Pairs camera bytes into RGB565 pixels and emits one luma byte per pixel, 2 cycles after byte 2.
// Optional rounding: define RGB565_TO_GRAYSCALE_ROUND_EN.
module rgb565_to_grayscale
  import grayscale_pkg::*;
#(
  parameter bit          high_byte_first = 1'b1,
  parameter int unsigned coeff_r         = LUMA_COEFF_R,
  parameter int unsigned coeff_g         = LUMA_COEFF_G,
  parameter int unsigned coeff_b         = LUMA_COEFF_B
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       data_in_valid,
  input  logic [7:0] data_in,
  output logic       data_out_valid,
  output logic [7:0] data_out,
  output logic       phase_error
);

  byte_phase_t phase_q;
  logic [7:0]  first_byte_q;
  logic        phase_error_q;
  logic        launch;
  logic        treat_as_first;
  logic [15:0] word;

  always_comb begin
    // frame_start on a valid byte resynchronises pairing to that byte.
    treat_as_first = data_in_valid && (frame_start || (phase_q == EXPECT_FIRST));
    launch         = data_in_valid && !frame_start && (phase_q == EXPECT_SECOND);
    word           = high_byte_first ? {first_byte_q, data_in} : {data_in, first_byte_q};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q       <= EXPECT_FIRST;
      first_byte_q  <= '0;
      phase_error_q <= 1'b0;
    end else begin
      phase_error_q <= data_in_valid && frame_start && (phase_q == EXPECT_SECOND);
      if (treat_as_first) begin
        first_byte_q <= data_in;
        phase_q      <= EXPECT_SECOND;
      end else if (launch) begin
        phase_q      <= EXPECT_FIRST;
      end
    end
  end

  rgb565_luma_pipe #(
    .coeff_r (coeff_r),
    .coeff_g (coeff_g),
    .coeff_b (coeff_b)
  ) u_pipe (
    .clock      (clock),
    .reset      (reset),
    .word_valid (launch),
    .word       (word),
    .luma_valid (data_out_valid),
    .luma       (data_out)
  );

  assign phase_error = phase_error_q;

endmodule

// File: tb/tb_rgb565_to_grayscale.sv
// Scoreboard bench: both byte orders driven from one stream, checked against an arithmetic model.
module tb_rgb565_to_grayscale;

  logic       clock = 1'b0;
  logic       reset;
  logic       frame_start;
  logic       data_in_valid;
  logic [7:0] data_in;
  logic       hi_valid, lo_valid, hi_pe, lo_pe;
  logic [7:0] hi_out, lo_out;

  always #5 clock = ~clock;

  rgb565_to_grayscale #(.high_byte_first(1'b1)) dut_hi (
    .clock          (clock),
    .reset          (reset),
    .frame_start    (frame_start),
    .data_in_valid  (data_in_valid),
    .data_in        (data_in),
    .data_out_valid (hi_valid),
    .data_out       (hi_out),
    .phase_error    (hi_pe)
  );

  rgb565_to_grayscale #(.high_byte_first(1'b0)) dut_lo (
    .clock          (clock),
    .reset          (reset),
    .frame_start    (frame_start),
    .data_in_valid  (data_in_valid),
    .data_in        (data_in),
    .data_out_valid (lo_valid),
    .data_out       (lo_out),
    .phase_error    (lo_pe)
  );

`ifdef RGB565_TO_GRAYSCALE_ROUND_EN
  localparam int Rnd = 128;
`else
  localparam int Rnd = 0;
`endif

  typedef struct {int val; int due;} exp_t;

  exp_t q_hi[$];
  exp_t q_lo[$];
  int   q_pe[$];
  int   edge_cnt = 0;
  int   total = 0;
  int   bad = 0;
  int   last_hi = 0;
  int   last_lo = 0;
  logic [7:0] pend;
  bit   pend_v = 1'b0;
  bit   done = 1'b0;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  function automatic int luma(input logic [15:0] w);
    int r, g, b, r8, g8, b8;
    r  = int'(w[15:11]);
    g  = int'(w[10:5]);
    b  = int'(w[4:0]);
    r8 = r * 8 + r / 4;
    g8 = g * 4 + g / 16;
    b8 = b * 8 + b / 4;
    return (77 * r8 + 150 * g8 + 29 * b8 + Rnd) / 256;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, expv, edge_cnt);
    end
  endtask

  // Monitor: pops expectations whenever a DUT presents an output.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (!done) begin
      if (q_hi.size() > 0 && q_hi[0].due < edge_cnt) begin
        e = q_hi.pop_front();
        check("hi_missing", 0, 1);
      end
      if (q_lo.size() > 0 && q_lo[0].due < edge_cnt) begin
        e = q_lo.pop_front();
        check("lo_missing", 0, 1);
      end
      if (q_pe.size() > 0 && q_pe[0] < edge_cnt) begin
        void'(q_pe.pop_front());
        check("pe_missing", 0, 1);
      end
      if (hi_valid) begin
        if (q_hi.size() == 0) check("hi_unexpected", 1, 0);
        else begin
          e = q_hi.pop_front();
          check("hi_data", hi_out, e.val);
          check("hi_latency", edge_cnt, e.due);
          last_hi = e.val;
        end
      end else check("hi_hold", hi_out, last_hi);
      if (lo_valid) begin
        if (q_lo.size() == 0) check("lo_unexpected", 1, 0);
        else begin
          e = q_lo.pop_front();
          check("lo_data", lo_out, e.val);
          check("lo_latency", edge_cnt, e.due);
          last_lo = e.val;
        end
      end else check("lo_hold", lo_out, last_lo);
      if (hi_pe || lo_pe) begin
        check("pe_match", lo_pe, hi_pe);
        if (q_pe.size() == 0) check("pe_unexpected", 1, 0);
        else check("pe_timing", edge_cnt, q_pe.pop_front());
      end
    end
  end

  // Drive one valid byte (called just after a falling edge); model decides pairing.
  task automatic send(input logic [7:0] b, input bit fs);
    int due;
    due           = edge_cnt + 3;
    data_in       = b;
    data_in_valid = 1'b1;
    frame_start   = fs;
    if (fs && pend_v) q_pe.push_back(edge_cnt + 1);
    if (fs || !pend_v) begin
      pend   = b;
      pend_v = 1'b1;
    end else begin
      q_hi.push_back('{luma({pend, b}), due});
      q_lo.push_back('{luma({b, pend}), due});
      pend_v = 1'b0;
    end
    @(negedge clock);
    data_in_valid = 1'b0;
    frame_start   = 1'b0;
    data_in       = 8'($urandom);
  endtask

  // Bubbles carry junk data and stray frame_start, both of which must be ignored.
  task automatic bubbles(input int n);
    repeat (n) begin
      frame_start = 1'($urandom_range(0, 1));
      data_in     = 8'($urandom);
      @(negedge clock);
    end
    frame_start = 1'b0;
  endtask

  task automatic apply_reset();
    #2;
    reset  = 1'b1;
    q_hi.delete();
    q_lo.delete();
    q_pe.delete();
    pend_v  = 1'b0;
    last_hi = 0;
    last_lo = 0;
    @(negedge clock);
    check("rst_valid", {hi_valid, lo_valid}, 2'b00);
    check("rst_data", {hi_out, lo_out}, 16'h0000);
    check("rst_pe", {hi_pe, lo_pe}, 2'b00);
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  logic [7:0] plan [10];

  initial begin
    plan = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF, 8'h00, 8'h00};
    reset         = 1'b1;
    frame_start   = 1'b0;
    data_in_valid = 1'b0;
    data_in       = 8'h00;
    repeat (3) @(negedge clock);
    check("reset_valid", {hi_valid, lo_valid}, 2'b00);
    check("reset_data", {hi_out, lo_out}, 16'h0000);
    check("reset_pe", {hi_pe, lo_pe}, 2'b00);
    reset = 1'b0;
    @(negedge clock);

    // Test-plan pixels, back-to-back then with bubbles.
    for (int i = 0; i < 10; i++) send(plan[i], i == 0);
    bubbles(4);
    for (int i = 0; i < 10; i++) begin
      send(plan[i], 1'b0);
      bubbles($urandom_range(0, 3));
    end
    bubbles(4);

    // Dangling first byte dropped by frame_start.
    send(8'hF8, 1'b0);
    send(8'hFF, 1'b1);
    send(8'hFF, 1'b0);
    bubbles(4);

    // Reset one cycle after a second byte, then mid-pixel, then a fresh pair.
    send(8'hF8, 1'b0);
    send(8'h00, 1'b0);
    apply_reset();
    send(8'h07, 1'b0);
    apply_reset();
    send(8'h07, 1'b0);
    send(8'hE0, 1'b0);
    bubbles(4);

    // Random stream with occasional resynchronising frame_start.
    for (int i = 0; i < 3000; i++) begin
      send(8'($urandom), $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 1) bubbles($urandom_range(1, 3));
    end
    bubbles(6);

    check("hi_drained", q_hi.size(), 0);
    check("lo_drained", q_lo.size(), 0);
    check("pe_drained", q_pe.size(), 0);
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rgb565_to_grayscale.md
# rgb565_to_grayscale

Converts the camera capture byte stream into one 8-bit luma sample per pixel. Pairs consecutive RGB565 bytes, expands each channel to 8 bits and computes a weighted luma sum. Sits directly upstream of `grayscale_downsampler` and drives its `data_in_valid`/`data_in` inputs. Has no backpressure, and its output stream has the same valid-only semantics as the downsampler's input.

## Interface
- `high_byte_first`, 1: 1 = first byte of a pixel carries bits [15:8] (R5,G6[5:3]); 0 = first byte carries [7:0].
- `coeff_r`, 77: red weight; coefficients must sum to 256.
- `coeff_g`, 150: green weight.
- `coeff_b`, 29: blue weight.

- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `frame_start`  in  1  one-cycle pulse marking the first byte of a frame; only meaningful when `data_in_valid`=1.
- `data_in_valid`  in  1  `data_in` carries a byte this cycle.
- `data_in`  in  8  camera byte.
- `data_out_valid`  out  1  one-cycle strobe per pixel.
- `data_out`  out  8  luma, 0..255.
- `phase_error`  out  1  one-cycle pulse when a dangling first byte is dropped.

## Operation
- Byte-phase FSM with two states, EXPECT_FIRST and EXPECT_SECOND.
  - EXPECT_FIRST, valid byte: latch it into `first_byte` and go to EXPECT_SECOND.
  - EXPECT_SECOND, valid byte: form a 16-bit word from `first_byte` and the new byte, ordered per `high_byte_first`. Launch it into the pipeline and go to EXPECT_FIRST.
  - Cycles with `data_in_valid`=0 (bubbles) leave state unchanged. Any number of bubbles may separate the two bytes of a pixel.
- `frame_start` with `data_in_valid`=1 forces that byte to be treated as a first byte.
  - If the FSM was in EXPECT_SECOND, the latched byte is discarded and `phase_error` pulses on the same edge.
  - `frame_start` with `data_in_valid`=0 is ignored.
- Channel expansion: R8 = {R5, R5[4:2]}, G8 = {G6, G6[5:4]}, B8 = {B5, B5[4:2]}.
- Luma: Y = (coeff_r·R8 + coeff_g·G8 + coeff_b·B8) >> 8.
  - Products are 16 bits; the sum is held in 17 bits.
  - With the coefficients summing to 256, Y ≤ 255, so no saturation logic is needed.
- Reset (asynchronous): FSM → EXPECT_FIRST, in-flight pipeline contents discarded.
  - `data_out_valid`=0, `data_out`=8'h00, `phase_error`=0.
  - Reset asserted mid-pixel or mid-pipeline produces no output for that pixel.

## Timing
- Pipeline stages:
  - Edge N samples the second byte of a pixel.
  - Edge N+1 registers the three products.
  - Edge N+2 registers the sum/shift into `data_out` and asserts `data_out_valid` for one cycle.
- Latency is fixed at 2 cycles from the second-byte edge and does not depend on bubbles.
- Throughput: one pixel per two valid bytes; back-to-back valid bytes every cycle are sustained, giving one output every 2 cycles.
- `data_out` holds its last value while `data_out_valid`=0.
- The pipeline always advances; there is no stall input.
- `phase_error` is registered: it is high in the cycle after the offending edge.

## Configuration
- `RGB565_TO_GRAYSCALE_ROUND_EN`:
  - Defined: add 128 before the >>8 (round-to-nearest). The maximum intermediate is 65408, which still fits in 17 bits.
  - Not defined: truncate (plain >>8).
  - Latency is identical either way.

## Structure
- Package `grayscale_pkg` holds:
  - default coefficients `LUMA_COEFF_R/G/B`;
  - `LUMA_SHIFT` = 8;
  - the byte-phase enum `byte_phase_t` {EXPECT_FIRST, EXPECT_SECOND}.
- Sub-module `rgb565_luma_pipe`: takes a 16-bit word plus valid, and performs expansion, the product stage and the sum/shift stage. The top level keeps the byte FSM and frame_start/phase_error handling.

## Test plan
- Bytes F8,00 / 07,E0 / 00,1F / FF,FF / 00,00 back-to-back, `high_byte_first`=1:
  - truncating build → outputs 76, 149, 28, 255, 0;
  - `_ROUND_EN` build → 77, 149, 29, 255, 0;
  - each output appears 2 cycles after its second byte.
- Same pixels with random 0–3-cycle bubbles between every byte → identical output values, each 2 cycles after its second byte.
- `high_byte_first`=0, bytes 00,F8 → 76 (truncating).
- Byte F8, then frame_start with byte FF, then byte FF → one `phase_error` pulse, and exactly one output of 255.
- Reset asserted one cycle after a second byte → no `data_out_valid`, outputs return to 0, and the FSM accepts a fresh pair afterwards.
- Full 320×240 frame (153600 bytes, random bubbles) fed into `grayscale_downsampler` (bin 4×8) → 76800 luma strobes; downsampler bins match a software model of luma then bin averaging.
